// File: rtl/mem_arb_rr.sv
// mem_arb_rr: one synchronous memory array shared by NUM_CH channels.
// A round-robin arbiter grants at most one channel per cycle. A granted
// write updates the array; a granted read returns data one cycle later,
// tagged through rvalid to the channel that issued it.
module mem_arb_rr #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      cand_idx;
  int unsigned           cand;
  logic                  gnt_any;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_CH];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_CH];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  // Split the flattened per-channel buses into arrays indexed by channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first requester at or after ptr, wrapping; nothing during reset.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cand     = (32'(ptr) + i) % NUM_CH;
        cand_idx = PTR_W'(cand);
        if (!gnt_any && req[cand_idx]) begin
          gnt_any       = 1'b1;
          gnt_idx       = cand_idx;
          gnt[cand_idx] = 1'b1;
        end
      end
    end
  end

  // Route the granted channel's command to the shared array.
  always_comb begin
    sel_we    = we[gnt_idx];
    sel_addr  = addr_a[gnt_idx];
    sel_wdata = wdata_a[gnt_idx];
  end

  // Priority pointer moves to the channel after the one just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Storage write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (!rst && gnt_any && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // Registered read return: rdata holds between reads, rvalid pulses one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else if (gnt_any && !sel_we) begin
      rvalid <= gnt;
      rdata  <= mem[sel_addr];
    end else begin
      rvalid <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arb_rr.sv
// Bench for mem_arb_rr: a 2-channel/8-bit and a 4-channel/16-bit instance
// checked every cycle against a behavioural arbiter/memory model, plus
// directed vectors with literal expectations.
module tb_mem_arb_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req2, we2, gnt2, rvalid2;
  logic [9:0]  addr2;
  logic [15:0] wdata2;
  logic [7:0]  rdata2;
  logic [3:0]  req4, we4, gnt4, rvalid4;
  logic [19:0] addr4;
  logic [63:0] wdata4;
  logic [15:0] rdata4;

  int vectors     = 0;
  int miscompares = 0;

  mem_arb_rr #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .NUM_CH(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2)
  );

  mem_arb_rr #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .NUM_CH(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ptr_m  [2];
  logic [15:0] mem_m  [2][32];
  logic [3:0]  rv_m   [2];
  logic [15:0] rd_m   [2];
  bit          armed = 1'b0;

  // Winner = requester with the smallest circular distance from the pointer.
  function automatic int pick(input logic [3:0] rq, input int n, input int p);
    int best = -1;
    int bd   = n;
    for (int k = 0; k < n; k++) begin
      if (rq[k] && ((k - p + n) % n) < bd) begin
        bd   = (k - p + n) % n;
        best = k;
      end
    end
    return best;
  endfunction

  task automatic model_step(input int d, input int n, input logic [3:0] rq,
                            input logic [3:0] wq, input logic [19:0] ad,
                            input logic [63:0] wd);
    int g;
    logic [4:0] a;
    if (rst) begin
      ptr_m[d] = 0;
      rv_m[d]  = '0;
      rd_m[d]  = '0;
      armed    = 1'b1;
    end else begin
      g = pick(rq, n, ptr_m[d]);
      if (g < 0) begin
        rv_m[d] = '0;
      end else begin
        a = ad[g*5 +: 5];
        if (wq[g]) begin
          mem_m[d][a] = wd[g*16 +: 16];
          rv_m[d]     = '0;
        end else begin
          rd_m[d] = mem_m[d][a];
          rv_m[d] = 4'b0001 << g;
        end
        ptr_m[d] = (g + 1) % n;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 2, {2'b00, req2}, {2'b00, we2}, {10'b0, addr2},
               {32'b0, 8'b0, wdata2[15:8], 8'b0, wdata2[7:0]});
    model_step(1, 4, req4, we4, addr4, wdata4);
  end

  // Compare both DUTs against the model at every falling edge once reset has been seen.
  always @(negedge clk) begin
    int g;
    logic [3:0] eg;
    if (armed) begin
      g  = pick({2'b00, req2}, 2, ptr_m[0]);
      eg = (rst || g < 0) ? 4'b0000 : (4'b0001 << g);
      chk("m2_gnt",    16'(gnt2),    16'(eg[1:0]));
      chk("m2_rvalid", 16'(rvalid2), 16'(rv_m[0][1:0]));
      chk("m2_rdata",  16'(rdata2),  16'(rd_m[0][7:0]));
      g  = pick(req4, 4, ptr_m[1]);
      eg = (rst || g < 0) ? 4'b0000 : (4'b0001 << g);
      chk("m4_gnt",    16'(gnt4),    16'(eg));
      chk("m4_rvalid", 16'(rvalid4), 16'(rv_m[1]));
      chk("m4_rdata",  rdata4,       rd_m[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc2(input logic r, input logic [1:0] rq, input logic [1:0] w,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk);
    #1;
    rst    = r;
    req2   = rq;
    we2    = w;
    addr2  = {a1, a0};
    wdata2 = {d1, d0};
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; req2 = 2'b11; we2 = 2'b00; addr2 = '0; wdata2 = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;

    // Reset held two cycles with both channels requesting
    @(negedge clk);
    chk("rst_gnt", 16'(gnt2), 16'h0);
    chk("rst_rvalid", 16'(rvalid2), 16'h0);
    chk("rst_rdata", 16'(rdata2), 16'h0);
    cyc2(1'b1, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
    chk("rst_gnt2", 16'(gnt2), 16'h0);

    // Preload addr0=11 (ch0), addr1=22 (ch1); first grant after reset is ch0
    cyc2(1'b0, 2'b11, 2'b11, 5'd0, 5'd1, 8'h11, 8'h22);
    chk("first_gnt", 16'(gnt2), 16'h1);
    cyc2(1'b0, 2'b10, 2'b10, 5'd0, 5'd1, 8'h11, 8'h22);
    chk("pre_gnt1", 16'(gnt2), 16'h2);

    // Single-channel write then read of addr 3
    cyc2(1'b0, 2'b01, 2'b01, 5'h03, 5'd1, 8'hA5, 8'h22);
    chk("sc_wr_gnt", 16'(gnt2), 16'h1);
    cyc2(1'b0, 2'b01, 2'b00, 5'h03, 5'd1, 8'hA5, 8'h22);
    chk("sc_rd_gnt", 16'(gnt2), 16'h1);
    chk("sc_wr_norv", 16'(rvalid2), 16'h0);
    cyc2(1'b0, 2'b10, 2'b00, 5'h03, 5'd1, 8'h00, 8'h00);
    chk("sc_rvalid", 16'(rvalid2), 16'h1);
    chk("sc_rdata", 16'(rdata2), 16'h00A5);

    // Contention: both channels read for six cycles
    for (int i = 0; i < 6; i++) begin
      cyc2(1'b0, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
      chk("ct_gnt", 16'(gnt2), (i % 2 == 0) ? 16'h1 : 16'h2);
      if (i == 0) begin
        chk("ct_rvalid", 16'(rvalid2), 16'h2);
        chk("ct_rdata", 16'(rdata2), 16'h22);
      end else begin
        chk("ct_rvalid", 16'(rvalid2), ((i - 1) % 2 == 0) ? 16'h1 : 16'h2);
        chk("ct_rdata", 16'(rdata2), ((i - 1) % 2 == 0) ? 16'h11 : 16'h22);
      end
    end

    // Read-after-write across channels at addr 1F
    cyc2(1'b0, 2'b10, 2'b10, 5'd0, 5'h1F, 8'h00, 8'h3C);
    chk("raw_wr_gnt", 16'(gnt2), 16'h2);
    chk("raw_prev_rvalid", 16'(rvalid2), 16'h2);
    chk("raw_prev_rdata", 16'(rdata2), 16'h22);
    cyc2(1'b0, 2'b01, 2'b00, 5'h1F, 5'h1F, 8'h00, 8'h00);
    chk("raw_rd_gnt", 16'(gnt2), 16'h1);
    chk("raw_wr_norv", 16'(rvalid2), 16'h0);
    cyc2(1'b0, 2'b00, 2'b00, 5'h1F, 5'h1F, 8'h00, 8'h00);
    chk("raw_rvalid", 16'(rvalid2), 16'h1);
    chk("raw_rdata", 16'(rdata2), 16'h3C);

    // Reset in the middle of contention
    cyc2(1'b0, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
    chk("mr_gnt_a", 16'(gnt2), 16'h2);
    cyc2(1'b0, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
    chk("mr_gnt_b", 16'(gnt2), 16'h1);
    chk("mr_rdata_b", 16'(rdata2), 16'h22);
    cyc2(1'b1, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
    chk("mr_rst_gnt", 16'(gnt2), 16'h0);
    chk("mr_pre_rvalid", 16'(rvalid2), 16'h1);
    chk("mr_pre_rdata", 16'(rdata2), 16'h11);
    cyc2(1'b0, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
    chk("mr_post_gnt", 16'(gnt2), 16'h1);
    chk("mr_post_rvalid", 16'(rvalid2), 16'h0);
    chk("mr_post_rdata", 16'(rdata2), 16'h0);
    cyc2(1'b0, 2'b11, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00);
    chk("mr_gnt_c", 16'(gnt2), 16'h2);
    chk("mr_rdata_c", 16'(rdata2), 16'h11);
    cyc2(1'b0, 2'b01, 2'b00, 5'h1F, 5'd1, 8'h00, 8'h00);
    chk("mr_keep_gnt", 16'(gnt2), 16'h1);
    chk("mr_rdata_d", 16'(rdata2), 16'h22);
    cyc2(1'b0, 2'b00, 2'b00, 5'h1F, 5'd1, 8'h00, 8'h00);
    chk("mr_keep_rvalid", 16'(rvalid2), 16'h1);
    chk("mr_keep_rdata", 16'(rdata2), 16'h3C);

    // Four-channel, 16-bit instance: each channel writes 1000+k to addr k
    @(posedge clk);
    #1;
    req4 = 4'hF;
    we4  = 4'hF;
    for (int k = 0; k < 4; k++) begin
      addr4[k*5 +: 5]   = 5'(k);
      wdata4[k*16 +: 16] = 16'h1000 + 16'(k);
    end
    @(negedge clk);
    chk("p4_wr_gnt", 16'(gnt4), 16'h1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      req4 = req4 & ~(4'b0001 << (i - 1));
      @(negedge clk);
      e = 4'b0001 << i;
      chk("p4_wr_gnt", 16'(gnt4), 16'(e));
    end

    // All four read continuously: grants rotate and data returns tagged
    @(posedge clk);
    #1;
    req4 = 4'hF;
    we4  = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      e = 4'b0001 << (i % 4);
      chk("p4_rd_gnt", 16'(gnt4), 16'(e));
      if (i > 0) begin
        e = 4'b0001 << ((i - 1) % 4);
        chk("p4_rvalid", 16'(rvalid4), 16'(e));
        chk("p4_rdata", rdata4, 16'h1000 + 16'((i - 1) % 4));
      end
    end
    @(posedge clk);
    #1;
    req4 = 4'h0;
    @(negedge clk);
    chk("p4_last_rvalid", 16'(rvalid4), 16'h8);
    chk("p4_last_rdata", rdata4, 16'h1003);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
